input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable cycles needed to accept a change; legal range 2..65535.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Run_raw_n  input  1  asynchronous, bouncy Run key; active-low.
REQ-005 Continue_raw_n  input  1  asynchronous, bouncy Continue key; active-low.
REQ-006 SW_raw  input  10  asynchronous slide-switch vector.
REQ-007 Run  output  1  debounced Run level; active-high.
REQ-008 Continue  output  1  debounced Continue level; active-high.
REQ-009 Run_pulse  output  1  single-cycle strobe on each accepted Run press.
REQ-010 Continue_pulse  output  1  single-cycle strobe on each accepted Continue press.
REQ-011 SW  output  10  conditioned switch vector, feeding the processor top.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer (s1, s2); edge 0 is the first edge that samples a new raw value into s1, and s2 holds it after edge 1.
REQ-013 Each key SHALL have an independent FSM with a 16-bit counter, states IDLE, PRESS_CHK, PRESSED, REL_CHK.
REQ-014 IDLE: synchronized key pressed -> PRESS_CHK with counter = 0; otherwise stay.
REQ-015 PRESS_CHK: key released -> IDLE; pressed and counter = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter increments.
REQ-016 PRESSED: key released -> REL_CHK with counter = 0; otherwise stay.
REQ-017 REL_CHK: key pressed -> PRESSED with no new pulse; released and counter = DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-018 Level output (Run/Continue) SHALL be 1 exactly in states PRESSED and REL_CHK (registered decode).
REQ-019 Pulse output SHALL be 1 for exactly one cycle, the first cycle after a PRESS_CHK->PRESSED transition; REL_CHK->PRESSED SHALL NOT pulse.
REQ-020 Latency with stable input: level rises (and pulse asserts) after edge DEBOUNCE_CYCLES+2; level falls after edge DEBOUNCE_CYCLES+2 counted from release.
REQ-021 A bounce shorter than DEBOUNCE_CYCLES SHALL restart qualification and produce no output change.
REQ-022 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-023 Simultaneous Run and Continue activity SHALL be handled independently; both pulses may assert in the same cycle.

Reset
REQ-024 Reset SHALL force all FSMs to IDLE and clear all counters.
REQ-025 Reset SHALL load key synchronizer flops with 1 (released) and SW synchronizer flops with 0.
REQ-026 Reset SHALL drive Run, Continue, Run_pulse, Continue_pulse = 0 and SW = 10'b0 in the following cycle.
REQ-027 Reset asserted mid-qualification SHALL discard the pending press; no pulse follows reset release until a fresh full qualification completes.

Configuration
REQ-028 Macro INPUT_COND_SW_DEBOUNCE_EN defined: SW SHALL be a register plus 16-bit counter, with s2_q holding the previous s2 value.
REQ-029 With the macro defined, the counter clears when s2 = SW or s2 != s2_q; when counter = DEBOUNCE_CYCLES-1, SW <= s2 and the counter clears; otherwise the counter increments.
REQ-030 With the macro defined, SW updates after edge DEBOUNCE_CYCLES+2.
REQ-031 Macro undefined: SW SHALL equal s2 directly (visible after edge 1), with no counter logic generated.

Verification (DEBOUNCE_CYCLES = 4)
REQ-032 Assert Reset 3 cycles -> all outputs 0, SW = 10'b0.
REQ-033 Run_raw_n low at edge 0, held 20 cycles, then high -> Run = 1 after edge 6; Run_pulse high for exactly that one cycle; Run = 0 six edges after release.
REQ-034 Run_raw_n pattern low 2, high 1, low 2, high 1, then low held -> exactly one Run_pulse, occurring 6 edges after the final falling edge.
REQ-035 While PRESSED, Run_raw_n high 2 cycles then low -> Run stays 1 throughout, no second pulse.
REQ-036 Both keys low at the same edge -> Run_pulse and Continue_pulse high in the same cycle; Reset during PRESS_CHK -> no pulse.
REQ-037 SW_raw = 10'b0000110001 -> SW matches after edge 1 (macro off) or edge 6 (macro on); a 2-cycle glitch to 10'b0 with the macro on -> SW unchanged.

Source files
------------

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Conditions the Run / Continue push-keys and the 10-bit slide-switch vector
//   before they reach the processor top. Every raw input is brought into the
//   Clk domain by a two-flop synchronizer. Each key then runs through its own
//   debounce FSM, which produces a registered level and a one-cycle press strobe.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a change
//                     (legal range 2..65535)
//
// Ports
//   Clk            in   system clock, rising-edge active
//   Reset          in   synchronous active-high reset
//   Run_raw_n      in   raw bouncy Run key, active-low
//   Continue_raw_n in   raw bouncy Continue key, active-low
//   SW_raw[9:0]    in   raw slide switches
//   Run            out  debounced Run level, active-high
//   Continue       out  debounced Continue level, active-high
//   Run_pulse      out  one-cycle strobe per accepted Run press
//   Continue_pulse out  one-cycle strobe per accepted Continue press
//   SW[9:0]        out  conditioned switch vector
//
// Configuration
//   INPUT_COND_SW_DEBOUNCE_EN : when defined, SW is debounced with the same
//                               stability window as the keys; otherwise SW
//                               is the synchronizer output.
// -----------------------------------------------------------------------------

// Debounce FSM for one active-low key: synchronizer, qualification counter and
// registered level/pulse outputs.
module input_conditioner_key #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw_n,
  output logic level,
  output logic pulse
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic        key_s1_r;
  logic        key_s2_r;
  logic        pressed_s;
  state_t      state_r;
  state_t      state_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_s;
  logic        level_r;
  logic        pulse_r;

  assign pressed_s = ~key_s2_r;

  // Synchronizer, FSM state, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_r <= 1'b1;
      key_s2_r <= 1'b1;
      state_r  <= IDLE;
      cnt_r    <= 16'd0;
      level_r  <= 1'b0;
      pulse_r  <= 1'b0;
    end else begin
      key_s1_r <= key_raw_n;
      key_s2_r <= key_s1_r;
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      // Outputs decode the next state so they line up with the state register.
      level_r  <= (state_s == PRESSED) || (state_s == REL_CHK);
      // Only a completed press qualification strobes; a release bounce that
      // returns to PRESSED does not.
      pulse_r  <= (state_r == PRESS_CHK) && (state_s == PRESSED);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (pressed_s) begin
          state_s = PRESS_CHK;
          cnt_s   = 16'd0;
        end else begin
          state_s = IDLE;
        end
      end
      PRESS_CHK: begin
        if (!pressed_s) begin
          state_s = IDLE;
          cnt_s   = 16'd0;
        end else if (cnt_r == CNT_MAX) begin
          state_s = PRESSED;
          cnt_s   = 16'd0;
        end else begin
          cnt_s   = cnt_r + 16'd1;
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_s = REL_CHK;
          cnt_s   = 16'd0;
        end else begin
          state_s = PRESSED;
        end
      end
      REL_CHK: begin
        if (pressed_s) begin
          state_s = PRESSED;
          cnt_s   = 16'd0;
        end else if (cnt_r == CNT_MAX) begin
          state_s = IDLE;
          cnt_s   = 16'd0;
        end else begin
          cnt_s   = cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 16'd0;
      end
    endcase
  end

  assign level = level_r;
  assign pulse = pulse_r;

endmodule

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_raw_n,
  input  logic       Continue_raw_n,
  input  logic [9:0] SW_raw,
  output logic       Run,
  output logic       Continue,
  output logic       Run_pulse,
  output logic       Continue_pulse,
  output logic [9:0] SW
);

  logic [9:0] sw_s1_r;
  logic [9:0] sw_s2_r;

  input_conditioner_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
    .clk       (Clk),
    .reset     (Reset),
    .key_raw_n (Run_raw_n),
    .level     (Run),
    .pulse     (Run_pulse)
  );

  input_conditioner_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_continue_key (
    .clk       (Clk),
    .reset     (Reset),
    .key_raw_n (Continue_raw_n),
    .level     (Continue),
    .pulse     (Continue_pulse)
  );

  // Two-flop synchronizer for the switch vector.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_s1_r <= 10'd0;
      sw_s2_r <= 10'd0;
    end else begin
      sw_s1_r <= SW_raw;
      sw_s2_r <= sw_s1_r;
    end
  end

`ifdef INPUT_COND_SW_DEBOUNCE_EN
  localparam logic [15:0] SW_CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [9:0]  sw_q_r;
  logic [9:0]  sw_r;
  logic [15:0] sw_cnt_r;

  // Switch debounce: the vector must hold one new value for the full window.
  // Any change restarts the window, as does matching the current output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_q_r   <= 10'd0;
      sw_r     <= 10'd0;
      sw_cnt_r <= 16'd0;
    end else begin
      sw_q_r <= sw_s2_r;
      if ((sw_s2_r == sw_r) || (sw_s2_r != sw_q_r)) begin
        sw_cnt_r <= 16'd0;
      end else if (sw_cnt_r == SW_CNT_MAX) begin
        sw_r     <= sw_s2_r;
        sw_cnt_r <= 16'd0;
      end else begin
        sw_cnt_r <= sw_cnt_r + 16'd1;
      end
    end
  end

  assign SW = sw_r;
`else
  assign SW = sw_s2_r;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int D = 4;
`ifdef INPUT_COND_SW_DEBOUNCE_EN
  localparam int SW_LAT = D + 2;
`else
  localparam int SW_LAT = 1;
`endif

  logic       Clk;
  logic       Reset;
  logic       Run_raw_n;
  logic       Continue_raw_n;
  logic [9:0] SW_raw;
  logic       Run;
  logic       Continue;
  logic       Run_pulse;
  logic       Continue_pulse;
  logic [9:0] SW;

  int errors;
  int checks;

  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Run_raw_n      (Run_raw_n),
    .Continue_raw_n (Continue_raw_n),
    .SW_raw         (SW_raw),
    .Run            (Run),
    .Continue       (Continue),
    .Run_pulse      (Run_pulse),
    .Continue_pulse (Continue_pulse),
    .SW             (SW)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Run_raw_n = 1'b1;
    Continue_raw_n = 1'b1;
    SW_raw = 10'd0;
    idle_cycles(3);
    checks++;
    if ({Run, Continue, Run_pulse, Continue_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {Run, Continue, Run_pulse, Continue_pulse});
    end
    checks++;
    if (SW !== 10'd0) begin
      errors++;
      $display("FAIL reset_sw: got %b expected 0000000000", SW);
    end
    Reset = 1'b0;
    idle_cycles(2);
  endtask

  // Hold Run low 20 edges, then release; level and pulse follow at edge 6.
  task automatic test_run_press();
    int pulses;
    pulses = 0;
    Run_raw_n = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (Run_pulse === 1'b1) pulses++;
      checks++;
      if (Run !== (e >= 6) || Run_pulse !== (e == 6)) begin
        errors++;
        $display("FAIL press_edge%0d: got Run=%b pulse=%b expected Run=%b pulse=%b",
                 e, Run, Run_pulse, (e >= 6), (e == 6));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL press_pulse_count: got %0d expected 1", pulses);
    end
    Run_raw_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (Run !== (e < 6) || Run_pulse !== 1'b0) begin
        errors++;
        $display("FAIL release_edge%0d: got Run=%b pulse=%b expected Run=%b pulse=0",
                 e, Run, Run_pulse, (e < 6));
      end
    end
  endtask

  // Short press bounces restart qualification; one pulse, 6 edges after last fall.
  task automatic test_bounce();
    logic pattern [0:5];
    int   pulses;
    pattern = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pulses = 0;
    for (int e = 0; e < 20; e++) begin
      Run_raw_n = (e < 6) ? pattern[e] : 1'b0;
      tick();
      if (Run_pulse === 1'b1) pulses++;
      checks++;
      if (Run !== (e >= 12) || Run_pulse !== (e == 12)) begin
        errors++;
        $display("FAIL bounce_edge%0d: got Run=%b pulse=%b expected Run=%b pulse=%b",
                 e, Run, Run_pulse, (e >= 12), (e == 12));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_pulse_count: got %0d expected 1", pulses);
    end
    Run_raw_n = 1'b1;
    idle_cycles(10);
  endtask

  // Release bounce while PRESSED keeps the level and produces no pulse.
  task automatic test_release_bounce();
    Run_raw_n = 1'b0;
    idle_cycles(10);
    checks++;
    if (Run !== 1'b1) begin
      errors++;
      $display("FAIL relbounce_setup: got Run=%b expected 1", Run);
    end
    for (int e = 0; e < 12; e++) begin
      Run_raw_n = (e < 2) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if (Run !== 1'b1 || Run_pulse !== 1'b0) begin
        errors++;
        $display("FAIL relbounce_edge%0d: got Run=%b pulse=%b expected Run=1 pulse=0",
                 e, Run, Run_pulse);
      end
    end
    Run_raw_n = 1'b1;
    idle_cycles(10);
  endtask

  // Both keys pressed at the same edge pulse together.
  task automatic test_both_keys();
    Run_raw_n = 1'b0;
    Continue_raw_n = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (Run_pulse !== (e == 6) || Continue_pulse !== (e == 6) ||
          Run !== (e >= 6) || Continue !== (e >= 6)) begin
        errors++;
        $display("FAIL both_edge%0d: got pulses=%b%b levels=%b%b expected pulses=%b%b levels=%b%b",
                 e, Run_pulse, Continue_pulse, Run, Continue,
                 (e == 6), (e == 6), (e >= 6), (e >= 6));
      end
    end
    Run_raw_n = 1'b1;
    Continue_raw_n = 1'b1;
    idle_cycles(10);
    checks++;
    if ({Run, Continue} !== 2'b00) begin
      errors++;
      $display("FAIL both_release: got %b expected 00", {Run, Continue});
    end
  endtask

  // Reset during PRESS_CHK discards the pending press.
  task automatic test_reset_mid_press();
    Run_raw_n = 1'b0;
    idle_cycles(4);
    Reset = 1'b1;
    Run_raw_n = 1'b1;
    tick();
    checks++;
    if ({Run, Run_pulse} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_out: got %b expected 00", {Run, Run_pulse});
    end
    tick();
    Reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++;
      if (Run !== 1'b0 || Run_pulse !== 1'b0) begin
        errors++;
        $display("FAIL midreset_edge%0d: got Run=%b pulse=%b expected 0 0", e, Run, Run_pulse);
      end
    end
  endtask

  // SW follows SW_raw after the configured latency; short glitch behaviour.
  task automatic test_switches();
    logic [9:0] vals [0:1];
    logic [9:0] prev;
    logic [9:0] exp_sw;
    vals = '{10'b0000110001, 10'b1010101010};
    prev = 10'd0;
    for (int v = 0; v < 2; v++) begin
      SW_raw = vals[v];
      for (int e = 0; e < 9; e++) begin
        tick();
        exp_sw = (e >= SW_LAT) ? vals[v] : prev;
        checks++;
        if (SW !== exp_sw) begin
          errors++;
          $display("FAIL sw_v%0d_edge%0d: got %b expected %b", v, e, SW, exp_sw);
        end
      end
      prev = vals[v];
    end
    for (int e = 0; e < 12; e++) begin
      SW_raw = (e < 2) ? 10'd0 : prev;
`ifdef INPUT_COND_SW_DEBOUNCE_EN
      exp_sw = prev;
`else
      exp_sw = (e == 1 || e == 2) ? 10'd0 : prev;
`endif
      tick();
      checks++;
      if (SW !== exp_sw) begin
        errors++;
        $display("FAIL sw_glitch_edge%0d: got %b expected %b", e, SW, exp_sw);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Reset = 1'b1;
    Run_raw_n = 1'b1;
    Continue_raw_n = 1'b1;
    SW_raw = 10'd0;
    test_reset();
    test_run_press();
    test_bounce();
    test_release_bounce();
    test_both_keys();
    test_reset_mid_press();
    test_switches();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
